// File: rtl/led_key_indicator.sv
// -----------------------------------------------------------------------------
// led_key_indicator
//
// Drives the board status LEDs for the keypad path. Input comes from the keypad
// scanner. The driver shows a press indicator and a CODE_W-bit code field. The
// press LED is stretched so that a short tap stays visible. The code field can
// show the live key, the last latched key, a blinking latched key, or the
// number of presses modulo 2^CODE_W.
//
// All outputs are registered. The pin polarity is applied on the final
// register, so that everything before it works on a logical "lit" vector.
//
// Ports
//   clk            system clock, all logic on posedge
//   sys_rst_n      asynchronous active-low reset
//   IsPressed      key held (synchronous to clk, already debounced)
//   keyboard_data  key code, meaningful only while IsPressed=1
//   mode           00 LIVE, 01 LATCH, 10 BLINK, 11 COUNT
//   led            led[CODE_W] = press LED, led[CODE_W-1:0] = code field
// -----------------------------------------------------------------------------
module led_key_indicator #(
    parameter int CODE_W      = 4,
    parameter int STRETCH_CYC = 2_700_000,
    parameter int BLINK_CYC   = 6_750_000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              clk,
    input  logic              sys_rst_n,
    input  logic              IsPressed,
    input  logic [CODE_W-1:0] keyboard_data,
    input  logic [1:0]        mode,
    output logic [CODE_W:0]   led
);

    typedef enum logic [1:0] {
        MODE_LIVE  = 2'b00,
        MODE_LATCH = 2'b01,
        MODE_BLINK = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

    localparam int SW = (STRETCH_CYC > 1) ? $clog2(STRETCH_CYC) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [SW-1:0]   STRETCH_LOAD = SW'(STRETCH_CYC - 1);
    localparam logic [BW-1:0]   BLINK_LAST   = BW'(BLINK_CYC - 1);
    localparam logic [CODE_W:0] LED_OFF      = {(CODE_W+1){(ACTIVE_LOW != 0)}};

    logic              press_q, press_d;
    logic [CODE_W-1:0] code_latch_q, code_latch_d;
    logic [CODE_W-1:0] press_cnt_q, press_cnt_d;
    logic [SW-1:0]     stretch_cnt_q, stretch_cnt_d;
    logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
    logic              blink_ph_q, blink_ph_d;
    mode_e             mode_q, mode_d;
    logic [CODE_W:0]   led_q, led_d;

    logic              rise;
    logic              blink_enter;
    logic [BW-1:0]     blink_cnt_eff;
    logic              blink_ph_eff;
    logic [CODE_W-1:0] code_lit;
    logic [CODE_W:0]   lit;

    always_comb begin
        press_d       = IsPressed;
        rise          = IsPressed & ~press_q;
        mode_d        = mode_e'(mode);

        code_latch_d  = code_latch_q;
        press_cnt_d   = press_cnt_q;
        stretch_cnt_d = stretch_cnt_q;
        if (stretch_cnt_q != '0) begin
            stretch_cnt_d = stretch_cnt_q - 1'b1;
        end
        // A rise always reloads the stretch timer, so a retrigger extends the
        // press LED rather than being ignored.
        if (rise) begin
            code_latch_d  = keyboard_data;
            press_cnt_d   = press_cnt_q + CODE_W'(1);
            stretch_cnt_d = STRETCH_LOAD;
        end

        // On the first cycle in BLINK, behave as if the counter had already
        // been cleared and the phase set to visible. That way the first
        // visible phase lasts a full BLINK_CYC cycles, starting right at
        // the mode change.
        blink_enter   = (mode_d == MODE_BLINK) && (mode_q != MODE_BLINK);
        blink_cnt_eff = blink_enter ? '0 : blink_cnt_q;
        blink_ph_eff  = blink_enter | blink_ph_q;
        blink_cnt_d   = blink_cnt_q;
        blink_ph_d    = blink_ph_q;
        if (mode_d == MODE_BLINK) begin
            if (blink_cnt_eff == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_eff;
            end else begin
                blink_cnt_d = blink_cnt_eff + 1'b1;
                blink_ph_d  = blink_ph_eff;
            end
        end

        code_lit = '0;
        case (mode_d)
            MODE_LIVE:  code_lit = IsPressed ? keyboard_data : '0;
            MODE_LATCH: code_lit = code_latch_q;
            MODE_BLINK: code_lit = blink_ph_eff ? code_latch_q : '0;
            MODE_COUNT: code_lit = press_cnt_q;
            default:    code_lit = '0;
        endcase

        lit   = {IsPressed | (stretch_cnt_q != '0), code_lit};
        led_d = (ACTIVE_LOW != 0) ? ~lit : lit;
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            press_q       <= 1'b0;
            code_latch_q  <= '0;
            press_cnt_q   <= '0;
            stretch_cnt_q <= '0;
            blink_cnt_q   <= '0;
            blink_ph_q    <= 1'b1;
            mode_q        <= MODE_LIVE;
            led_q         <= LED_OFF;
        end else begin
            press_q       <= press_d;
            code_latch_q  <= code_latch_d;
            press_cnt_q   <= press_cnt_d;
            stretch_cnt_q <= stretch_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_ph_q    <= blink_ph_d;
            mode_q        <= mode_d;
            led_q         <= led_d;
        end
    end

    assign led = led_q;

endmodule
